vend_seq: RTL and testbench
===========================

# vend_seq

Transaction sequencer for the coin vending datapath. Conditions the raw `co5`/`co10`/`pay` switch inputs, keeps the credit register, and fires the one-cycle vend strobe. Returns change one 5-unit coin at a time over a req/ack handshake to the coin dispenser. Exports credit as two BCD digits to the 7-segment scan/mux stage, which owns `seg`/`ctrl`.

## Interface
- `PRICE`, 15: item price in units; multiple of 5, range 5..95.
- `CREDIT_MAX`, 95: maximum credit; multiple of 5, ≥ `PRICE`, ≤ 95.
- `ck` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `co5` in 1: 5-unit coin switch, level, asynchronous.
- `co10` in 1: 10-unit coin switch, level, asynchronous.
- `pay` in 1: purchase button, level, asynchronous.
- `chg_ack` in 1: dispenser acknowledge for one returned coin.
- `payok` out 1: vend strobe, one cycle.
- `change` out 1: change-coin request, held until acknowledged.
- `reject` out 1: coin-rejected strobe, one cycle.
- `busy` out 1: high in any state other than IDLE.
- `cred_tens` out 4: BCD tens digit of credit.
- `cred_ones` out 4: BCD ones digit of credit, 0 or 5.

## Operation
- Each of `co5`/`co10`/`pay` passes through a 2-flop synchronizer and a rising-edge detector. Only the edge acts; a held level is one event.
- Credit register is 7 bits, unsigned, always a multiple of 5, 0..`CREDIT_MAX`.
- `cred_tens` = credit/10 and `cred_ones` = credit%10, combinational from the credit register.
- FSM states are IDLE, VEND, CHANGE and CHG_GAP.
- IDLE, coin edge:
  - If credit + coin ≤ `CREDIT_MAX`, add the coin.
  - Otherwise leave credit unchanged and pulse `reject`.
- IDLE, `co5` and `co10` edges in the same cycle: `co10` is processed, `co5` is rejected.
- IDLE, `pay` edge with no coin edge that cycle:
  - If credit ≥ `PRICE`, go to VEND.
  - Otherwise see Configuration.
- IDLE, coin edge and `pay` edge in the same cycle: the coin is processed and the `pay` edge is discarded.
- VEND (exactly one cycle):
  - `payok`=1 and credit -= `PRICE`.
  - Next state is CHANGE if the remaining credit > 0, else IDLE.
- CHANGE:
  - `change`=1.
  - On the cycle `chg_ack`=1 is sampled: credit -= 5, `change` drops next cycle, go to CHG_GAP.
- CHG_GAP:
  - `change`=0; wait for `chg_ack`=0.
  - Then go to CHANGE if credit > 0, else IDLE.
- Coin edges in any non-IDLE state are rejected with a `reject` pulse and leave credit unchanged.
- `pay` edges in any non-IDLE state are ignored.
- `chg_ack` outside CHANGE has no effect.

## Timing
- Reset asserted: state=IDLE, credit=0, `payok`=0, `change`=0, `reject`=0, `busy`=0, `cred_tens`=0, `cred_ones`=0. Synchronizer and edge flops clear to 0.
- Reset mid-transaction drops `change` immediately and forfeits credit; there is no resume.
- Input latency: an input rising before edge k updates credit/state at edge k+2. The new digits are visible after edge k+2.
- `reject` and `payok` are registered one-cycle pulses, asserted in the cycle after the deciding edge.
- The change handshake is 4-phase: req high until ack sampled high, then req low until ack sampled low. One coin is returned per full handshake.
- Minimum handshake is 2 cycles per returned coin, with `chg_ack` tied to `change`.
- Vend to first `change` assertion: 1 cycle after `payok`.

## Configuration
- `VEND_REFUND_EN` defined:
  - A `pay` edge in IDLE with 0 < credit < `PRICE` goes directly to CHANGE and returns all credit in 5-unit coins.
  - `payok` is not asserted.
- `VEND_REFUND_EN` undefined: that `pay` edge is ignored and credit is retained.
- With credit = 0, a `pay` edge is ignored in both builds.

## Test plan
- Reset low 100 ns, then high. Insert co5, co10, co10 with ~5-cycle pulses → digits go 0/5 → 1/5 → 2/5, with no `reject`.
- From credit 25, pulse `pay` → one `payok` pulse, credit 10, then two `change` handshakes with a 2-cycle `chg_ack` response → credit 5 then 0, back to IDLE, `busy`=0.
- Drive co5 and co10 rising in the same cycle at credit 0 → credit 10, one `reject` pulse. Insert coins to 95, then co5 → `reject`, credit stays 95.
- Credit 10, pulse `pay`:
  - Without `VEND_REFUND_EN` → no `payok`, no `change`, credit 10.
  - With `VEND_REFUND_EN` → no `payok`, two change coins, credit 0.
- During the CHANGE state, pulse co10 and `pay` → `reject` on co10, `pay` ignored, change sequence unaffected.
- Hold `chg_ack` low in CHANGE for 50 cycles → `change` stays high and credit is unchanged. Assert `reset` → `change`=0 and credit=0 within the same cycle.

Source files
------------

// File: rtl/vend_seq.sv
// vend_seq: coin vending transaction sequencer (credit register, vend strobe, change return).
// Latency: a switch input rising before edge k acts at edge k+2; payok/reject are registered pulses.
// Backpressure: the change request is held until chg_ack; coin edges outside IDLE are rejected.
//
// Ports: ck, reset (async active-low); co5/co10/pay raw level switches; chg_ack dispenser ack;
//        payok vend strobe; change coin request; reject coin-reject strobe; busy (not IDLE);
//        cred_tens/cred_ones BCD digits of the credit register.
// Build option: define VEND_REFUND_EN to refund sub-price credit on a pay press.
module vend_seq #(
    parameter int PRICE      = 15,
    parameter int CREDIT_MAX = 95
) (
    input  logic       ck,
    input  logic       reset,
    input  logic       co5,
    input  logic       co10,
    input  logic       pay,
    input  logic       chg_ack,
    output logic       payok,
    output logic       change,
    output logic       reject,
    output logic       busy,
    output logic [3:0] cred_tens,
    output logic [3:0] cred_ones
);
    localparam logic [6:0] PRICE_C = 7'(PRICE);
    localparam logic [6:0] CMAX_C  = 7'(CREDIT_MAX);
    localparam logic [6:0] COIN5   = 7'd5;
    localparam logic [6:0] COIN10  = 7'd10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2,
        CHG_GAP = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] credit, credit_nxt;
    logic       payok_nxt, reject_nxt;

    // Two-flop synchronizers plus one history flop per switch for edge detection.
    logic [1:0] co5_sync, co10_sync, pay_sync;
    logic       co5_prev, co10_prev, pay_prev;
    logic       co5_edge, co10_edge, pay_edge, coin_edge;
    logic [6:0] coin_val;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            co5_sync  <= '0;
            co10_sync <= '0;
            pay_sync  <= '0;
            co5_prev  <= 1'b0;
            co10_prev <= 1'b0;
            pay_prev  <= 1'b0;
        end else begin
            co5_sync  <= {co5_sync[0], co5};
            co10_sync <= {co10_sync[0], co10};
            pay_sync  <= {pay_sync[0], pay};
            co5_prev  <= co5_sync[1];
            co10_prev <= co10_sync[1];
            pay_prev  <= pay_sync[1];
        end
    end

    assign co5_edge  = co5_sync[1]  & ~co5_prev;
    assign co10_edge = co10_sync[1] & ~co10_prev;
    assign pay_edge  = pay_sync[1]  & ~pay_prev;
    assign coin_edge = co5_edge | co10_edge;
    // When both coins arrive together the 10 wins and the 5 is rejected below.
    assign coin_val  = co10_edge ? COIN10 : COIN5;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            credit <= '0;
            payok  <= 1'b0;
            reject <= 1'b0;
        end else begin
            state  <= state_nxt;
            credit <= credit_nxt;
            payok  <= payok_nxt;
            reject <= reject_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        credit_nxt = credit;
        payok_nxt  = 1'b0;
        reject_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (coin_edge) begin
                    // A coin edge takes priority; a simultaneous pay edge is dropped.
                    if (co5_edge && co10_edge) begin
                        reject_nxt = 1'b1;
                    end
                    if (credit + coin_val <= CMAX_C) begin
                        credit_nxt = credit + coin_val;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end else if (pay_edge) begin
                    if (credit >= PRICE_C) begin
                        state_nxt = VEND;
                        payok_nxt = 1'b1;   // payok is high exactly while in VEND
                    end
`ifdef VEND_REFUND_EN
                    else if (credit != '0) begin
                        state_nxt = CHANGE;
                    end
`endif
                end
            end
            VEND: begin
                credit_nxt = credit - PRICE_C;
                state_nxt  = (credit != PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (chg_ack) begin
                    credit_nxt = credit - COIN5;
                    state_nxt  = CHG_GAP;
                end
            end
            CHG_GAP: begin
                if (!chg_ack) begin
                    state_nxt = (credit != '0) ? CHANGE : IDLE;
                end
            end
        endcase
        // The machine only accepts coins while idle.
        if (state != IDLE && coin_edge) begin
            reject_nxt = 1'b1;
        end
    end

    assign change    = (state == CHANGE);
    assign busy      = (state != IDLE);
    assign cred_tens = 4'(credit / 7'd10);
    assign cred_ones = 4'(credit % 7'd10);

endmodule

// File: tb/tb_vend_seq.sv
// tb_vend_seq: directed and randomized checks of vend_seq against a transaction-level model.
// Latency: model applies a switch rising before edge k at edge k+2; outputs compared every negedge.
// Backpressure: an emulated dispenser answers change with a programmable ack delay or holds ack low.
module tb_vend_seq;
    localparam int PRICE = 15;
    localparam int CMAX  = 95;
`ifdef VEND_REFUND_EN
    localparam bit REFUND = 1'b1;
`else
    localparam bit REFUND = 1'b0;
`endif

    logic       ck = 1'b0;
    logic       reset, co5, co10, pay, chg_ack;
    logic       payok, change, reject, busy;
    logic [3:0] cred_tens, cred_ones;

    vend_seq #(.PRICE(PRICE), .CREDIT_MAX(CMAX)) dut (
        .ck(ck), .reset(reset), .co5(co5), .co10(co10), .pay(pay), .chg_ack(chg_ack),
        .payok(payok), .change(change), .reject(reject), .busy(busy),
        .cred_tens(cred_tens), .cred_ones(cred_ones)
    );

    always #5 ck = ~ck;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: credit as an integer, plus "selling", "returning coins" and
    // "request raised" flags describing the customer-visible transaction.
    int       m_credit;
    bit       m_selling, m_returning, m_req, m_reject;
    bit [2:0] h5, h10, hp;   // input levels for the last three edges, [0] newest

    // Emulated dispenser.
    bit ack_lvl, ack_hold;
    int ack_lat, ack_wait;

    // Observed pulse/edge counts for directed checks.
    int payok_seen, reject_seen, change_rises;
    bit change_prev;

    task automatic chk_val(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit    = 0;
        m_selling   = 1'b0;
        m_returning = 1'b0;
        m_req       = 1'b0;
        m_reject    = 1'b0;
        h5 = '0; h10 = '0; hp = '0;
        change_prev = 1'b0;
    endtask

    task automatic model_edge(input bit c5, input bit c10, input bit p, input bit ack);
        bit ev5, ev10, evp;
        int coin;
        ev5  = h5[1]  & ~h5[2];
        ev10 = h10[1] & ~h10[2];
        evp  = hp[1]  & ~hp[2];
        h5  = {h5[1:0], c5};
        h10 = {h10[1:0], c10};
        hp  = {hp[1:0], p};
        m_reject = 1'b0;
        if (m_selling) begin
            m_selling   = 1'b0;
            m_credit    = m_credit - PRICE;
            m_returning = (m_credit > 0);
            m_req       = m_returning;
            if (ev5 || ev10) m_reject = 1'b1;
        end else if (m_returning) begin
            if (ev5 || ev10) m_reject = 1'b1;
            if (m_req && ack) begin
                m_credit = m_credit - 5;
                m_req    = 1'b0;
            end else if (!m_req && !ack) begin
                if (m_credit > 0) m_req = 1'b1;
                else m_returning = 1'b0;
            end
        end else begin
            if (ev5 || ev10) begin
                coin = ev10 ? 10 : 5;
                if (ev5 && ev10) m_reject = 1'b1;
                if (m_credit + coin <= CMAX) m_credit = m_credit + coin;
                else m_reject = 1'b1;
            end else if (evp) begin
                if (m_credit >= PRICE) begin
                    m_selling = 1'b1;
                end else if (REFUND && m_credit > 0) begin
                    m_returning = 1'b1;
                    m_req       = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk_val("payok",  int'(payok),  int'(m_selling));
        chk_val("reject", int'(reject), int'(m_reject));
        chk_val("change", int'(change), int'(m_req));
        chk_val("busy",   int'(busy),   int'(m_selling || m_returning));
        chk_val("tens",   int'(cred_tens), m_credit / 10);
        chk_val("ones",   int'(cred_ones), m_credit % 10);
        payok_seen  += int'(payok);
        reject_seen += int'(reject);
        if (change && !change_prev) change_rises++;
        change_prev = change;
    endtask

    // Called at a negedge: drive inputs for the next posedge, advance the model, check at next negedge.
    task automatic step(input bit c5, input bit c10, input bit p);
        if (ack_hold) begin
            ack_lvl  = 1'b0;
            ack_wait = 0;
        end else if (change != ack_lvl) begin
            if (ack_wait >= ack_lat) begin
                ack_lvl  = change;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
        co5 = c5; co10 = c10; pay = p; chg_ack = ack_lvl;
        model_edge(c5, c10, p, ack_lvl);
        @(negedge ck);
        check_outputs();
    endtask

    task automatic pulse(input bit c5, input bit c10, input bit p);
        repeat (2) step(c5, c10, p);
        repeat (3) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        payok_seen = 0; reject_seen = 0; change_rises = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        co5 = 1'b0; co10 = 1'b0; pay = 1'b0; chg_ack = 1'b0;
        ack_lvl = 1'b0; ack_wait = 0;
        #1;
        chk_val("rst_change", int'(change), 0);
        chk_val("rst_busy",   int'(busy),   0);
        chk_val("rst_payok",  int'(payok),  0);
        chk_val("rst_reject", int'(reject), 0);
        chk_val("rst_tens",   int'(cred_tens), 0);
        chk_val("rst_ones",   int'(cred_ones), 0);
        model_reset();
        repeat (n) @(negedge ck);
        reset = 1'b1;
    endtask

    initial begin
        bit r5, r10, rp;
        reset = 1'b0; co5 = 1'b0; co10 = 1'b0; pay = 1'b0; chg_ack = 1'b0;
        ack_hold = 1'b0; ack_lat = 0; ack_wait = 0; ack_lvl = 1'b0;
        model_reset();
        clr_counts();
        @(negedge ck);
        do_reset(9);

        // Coin insertion: 0/5 -> 1/5 -> 2/5, nothing rejected.
        idle(3);
        pulse(1'b1, 1'b0, 1'b0);
        chk_val("t1_c5_ones", int'(cred_ones), 5);
        pulse(1'b0, 1'b1, 1'b0);
        chk_val("t1_c15_tens", int'(cred_tens), 1);
        pulse(1'b0, 1'b1, 1'b0);
        chk_val("t1_c25_tens", int'(cred_tens), 2);
        chk_val("t1_c25_ones", int'(cred_ones), 5);
        chk_val("t1_rejects", reject_seen, 0);

        // Vend from 25 with a 2-cycle dispenser: one payok, two coins back.
        clr_counts();
        ack_lat = 2;
        pulse(1'b0, 1'b0, 1'b1);
        idle(30);
        chk_val("t2_payok", payok_seen, 1);
        chk_val("t2_coins", change_rises, 2);
        chk_val("t2_tens", int'(cred_tens), 0);
        chk_val("t2_ones", int'(cred_ones), 0);
        chk_val("t2_busy", int'(busy), 0);

        // Simultaneous co5+co10 at 0, then fill to 95 and overflow.
        clr_counts();
        pulse(1'b1, 1'b1, 1'b0);
        chk_val("t3_both_tens", int'(cred_tens), 1);
        chk_val("t3_both_ones", int'(cred_ones), 0);
        chk_val("t3_both_rej", reject_seen, 1);
        repeat (8) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk_val("t3_full_tens", int'(cred_tens), 9);
        pulse(1'b1, 1'b0, 1'b0);
        chk_val("t3_ovf_rej", reject_seen, 2);
        chk_val("t3_ovf_tens", int'(cred_tens), 9);
        chk_val("t3_ovf_ones", int'(cred_ones), 5);

        // Vend from 95: 80 returned as 16 coins with ack tied to change.
        clr_counts();
        ack_lat = 0;
        pulse(1'b0, 1'b0, 1'b1);
        idle(40);
        chk_val("t4_coins95", change_rises, 16);
        chk_val("t4_payok95", payok_seen, 1);
        chk_val("t4_tens95", int'(cred_tens), 0);

        // Pay with credit 10 (below price).
        pulse(1'b0, 1'b1, 1'b0);
        clr_counts();
        pulse(1'b0, 1'b0, 1'b1);
        idle(20);
        chk_val("t4_low_payok", payok_seen, 0);
        chk_val("t4_low_coins", change_rises, REFUND ? 2 : 0);
        chk_val("t4_low_tens", int'(cred_tens), REFUND ? 0 : 1);
        chk_val("t4_low_busy", int'(busy), 0);

        // Coin and pay during CHANGE: coin rejected, pay ignored, return completes.
        do_reset(3);
        clr_counts();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        ack_hold = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        idle(3);
        chk_val("t5_in_change", int'(change), 1);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        chk_val("t5_rej", reject_seen, 1);
        chk_val("t5_hold_chg", int'(change), 1);
        chk_val("t5_hold_ones", int'(cred_ones), 5);
        ack_hold = 1'b0;
        ack_lat  = 1;
        idle(12);
        chk_val("t5_payok", payok_seen, 1);
        chk_val("t5_coins", change_rises, 1);
        chk_val("t5_busy", int'(busy), 0);
        chk_val("t5_ones", int'(cred_ones), 0);

        // Ack held low for 50 cycles, then reset mid-return.
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        ack_hold = 1'b1;
        pulse(1'b0, 1'b0, 1'b1);
        idle(3);
        idle(50);
        chk_val("t6_stall_chg", int'(change), 1);
        chk_val("t6_stall_tens", int'(cred_tens), 1);
        chk_val("t6_stall_ones", int'(cred_ones), 0);
        do_reset(3);
        ack_hold = 1'b0;

        // Randomized switch activity with varying dispenser latency.
        r5 = 1'b0; r10 = 1'b0; rp = 1'b0;
        for (int i = 0; i < 2400; i++) begin
            if (i % 300 == 0) ack_lat = $urandom_range(0, 3);
            if (i == 1200) do_reset(3);
            if ($urandom_range(0, 7) == 0) r5  = ~r5;
            if ($urandom_range(0, 7) == 0) r10 = ~r10;
            if ($urandom_range(0, 7) == 0) rp  = ~rp;
            step(r5, r10, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
